// File: rtl/fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_writer
// Brief    : Streams upstream samples into a downstream FIFO through a
//            2-entry in-order skid buffer, stopping writes AFULL_MARGIN words
//            below capacity. Samples arriving while the buffer is full are
//            dropped; a sticky overflow flag and a saturating drop counter
//            record them.
// Options  : FIFO_WRITER_DROP_CNT_EN - define to build the drop counter;
//            without it drop_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_writer #(
   parameter int D_WIDTH      = 24,
   parameter int USEDW_WIDTH  = 8,
   parameter int FIFO_DEPTH   = 256,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [D_WIDTH-1:0]     data_i,
   input  logic                   ena_i,
   output logic                   ready_o,
   input  logic                   full_i,
   input  logic [USEDW_WIDTH-1:0] usedw_i,
   output logic                   wrreq_o,
   output logic [D_WIDTH-1:0]     data_o,
   input  logic                   clr_i,
   output logic                   ovf_o,
   output logic [15:0]            drop_cnt_o
);

   // Fill level at which writing stops; one extra bit so a level equal to
   // 2**USEDW_WIDTH still compares correctly.
   localparam logic [USEDW_WIDTH:0] AFULL_LEVEL =
      (USEDW_WIDTH+1)'(FIFO_DEPTH - AFULL_MARGIN);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [D_WIDTH-1:0] buf0;        // oldest buffered word
   logic [D_WIDTH-1:0] buf1;        // newer buffered word (state TWO only)
   logic [D_WIDTH-1:0] buf0_next;
   logic [D_WIDTH-1:0] buf1_next;
   logic               wr_next;
   logic [D_WIDTH-1:0] wdata_next;
   logic               push;
   logic               drop;
   logic               can_wr;

   // ready_o is registered, so it already reflects whether a slot is free.
   assign push   = ena_i & ready_o;
   assign drop   = ena_i & ~ready_o;
   assign can_wr = ~full_i & ({1'b0, usedw_i} < AFULL_LEVEL);

   // Next state, buffer update and write selection; oldest word always wins.
   always_comb begin
      state_next = state;
      buf0_next  = buf0;
      buf1_next  = buf1;
      wr_next    = 1'b0;
      wdata_next = data_o;
      case (state)
         EMPTY: begin
            if (push) begin
               if (can_wr) begin
                  // Pass-through: nothing older is waiting.
                  wr_next    = 1'b1;
                  wdata_next = data_i;
               end else begin
                  state_next = ONE;
                  buf0_next  = data_i;
               end
            end
         end
         ONE: begin
            if (can_wr) begin
               wr_next    = 1'b1;
               wdata_next = buf0;
               if (push) begin
                  buf0_next = data_i;
               end else begin
                  state_next = EMPTY;
               end
            end else if (push) begin
               state_next = TWO;
               buf1_next  = data_i;
            end
         end
         TWO: begin
            // ready_o is low here, so no push can arrive.
            if (can_wr) begin
               wr_next    = 1'b1;
               wdata_next = buf0;
               buf0_next  = buf1;
               state_next = ONE;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // State, buffer and FIFO-side output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= EMPTY;
         buf0    <= '0;
         buf1    <= '0;
         wrreq_o <= 1'b0;
         data_o  <= '0;
         ready_o <= 1'b0;
      end else begin
         state   <= state_next;
         buf0    <= buf0_next;
         buf1    <= buf1_next;
         wrreq_o <= wr_next;
         data_o  <= wdata_next;
         ready_o <= (state_next != TWO);
      end
   end

   // Sticky overflow flag; a drop in the clear cycle survives the clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
      end else if (clr_i) begin
         ovf_o <= drop;
      end else if (drop) begin
         ovf_o <= 1'b1;
      end
   end

`ifdef FIFO_WRITER_DROP_CNT_EN
   // Saturating dropped-sample counter; a drop in the clear cycle counts as 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_cnt_o <= '0;
      end else if (clr_i) begin
         drop_cnt_o <= {15'd0, drop};
      end else if (drop && (drop_cnt_o != 16'hFFFF)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`else
   assign drop_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_writer
// Brief    : Directed self-checking bench for fifo_writer (default params).
//            Follows FIFO_WRITER_DROP_CNT_EN to choose counter expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_writer;

   logic        clk_i;
   logic        rst_i;
   logic [23:0] data_i;
   logic        ena_i;
   logic        ready_o;
   logic        full_i;
   logic [7:0]  usedw_i;
   logic        wrreq_o;
   logic [23:0] data_o;
   logic        clr_i;
   logic        ovf_o;
   logic [15:0] drop_cnt_o;

   int checks = 0;
   int errors = 0;

   fifo_writer dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .data_i     (data_i),
      .ena_i      (ena_i),
      .ready_o    (ready_o),
      .full_i     (full_i),
      .usedw_i    (usedw_i),
      .wrreq_o    (wrreq_o),
      .data_o     (data_o),
      .clr_i      (clr_i),
      .ovf_o      (ovf_o),
      .drop_cnt_o (drop_cnt_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance one rising edge, then settle 1 ns before sampling/driving.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic exp_wr, input logic [23:0] exp_data);
      check({tag, ".wrreq"}, {31'd0, wrreq_o}, {31'd0, exp_wr});
      check({tag, ".data"},  {8'd0, data_o},   {8'd0, exp_data});
   endtask

   logic [15:0] exp_cnt;

   initial begin
      rst_i   = 1'b1;
      data_i  = '0;
      ena_i   = 1'b0;
      full_i  = 1'b0;
      usedw_i = '0;
      clr_i   = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check_wr("rst", 1'b0, 24'h0);
      check("rst.ready", {31'd0, ready_o}, 32'd0);
      check("rst.ovf",   {31'd0, ovf_o},   32'd0);
      check("rst.cnt",   {16'd0, drop_cnt_o}, 32'd0);
      rst_i = 1'b0;
      tick();
      check("rel.ready", {31'd0, ready_o}, 32'd1);

      // ---------------- pass-through burst 1..4 ----------------
      for (int i = 1; i <= 4; i++) begin
         ena_i  = 1'b1;
         data_i = 24'(i);
         tick();
         check_wr($sformatf("burst%0d", i), 1'b1, 24'(i));
      end
      ena_i = 1'b0;
      tick();
      check_wr("burst.idle", 1'b0, 24'd4);

      // ---------------- almost-full stall at 254 ----------------
      usedw_i = 8'd254;
      ena_i   = 1'b1;
      data_i  = 24'hA1;
      tick();
      check_wr("af.a1", 1'b0, 24'd4);
      check("af.a1.ready", {31'd0, ready_o}, 32'd1);
      data_i = 24'hA2;
      tick();
      check_wr("af.a2", 1'b0, 24'd4);
      check("af.two.ready", {31'd0, ready_o}, 32'd0);
      ena_i = 1'b0;
      tick();
      check("af.hold.ready", {31'd0, ready_o}, 32'd0);
      check("af.hold.ovf",   {31'd0, ovf_o},   32'd0);
      usedw_i = 8'd10;
      tick();
      check_wr("af.drain1", 1'b1, 24'hA1);
      check("af.drain1.ready", {31'd0, ready_o}, 32'd1);
      tick();
      check_wr("af.drain2", 1'b1, 24'hA2);
      tick();
      check_wr("af.done", 1'b0, 24'hA2);

      // ---------------- boundary: 253 still writable ----------------
      usedw_i = 8'd253;
      ena_i   = 1'b1;
      data_i  = 24'hC0;
      tick();
      check_wr("b253", 1'b1, 24'hC0);
      ena_i = 1'b0;

      // ---------------- drops while TWO, clear ----------------
      usedw_i = 8'd254;
      ena_i   = 1'b1;
      data_i  = 24'hB1;
      tick();
      data_i = 24'hB2;
      tick();
      check("dr.ready", {31'd0, ready_o}, 32'd0);
      data_i = 24'hBF;
      for (int i = 1; i <= 3; i++) begin
         tick();
      end
      ena_i = 1'b0;
`ifdef FIFO_WRITER_DROP_CNT_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      check("dr.ovf", {31'd0, ovf_o}, 32'd1);
      check("dr.cnt", {16'd0, drop_cnt_o}, {16'd0, exp_cnt});
      check_wr("dr.nowr", 1'b0, 24'hC0);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr.ovf", {31'd0, ovf_o}, 32'd0);
      check("clr.cnt", {16'd0, drop_cnt_o}, 32'd0);
      // clear and drop in the same cycle
      clr_i = 1'b1;
      ena_i = 1'b1;
      tick();
      ena_i = 1'b0;
`ifdef FIFO_WRITER_DROP_CNT_EN
      exp_cnt = 16'd1;
`else
      exp_cnt = 16'd0;
`endif
      check("clrdrop.ovf", {31'd0, ovf_o}, 32'd1);
      check("clrdrop.cnt", {16'd0, drop_cnt_o}, {16'd0, exp_cnt});
      tick();
      clr_i = 1'b0;
      check("clr2.ovf", {31'd0, ovf_o}, 32'd0);

      // ---------------- saturation ----------------
`ifdef FIFO_WRITER_DROP_CNT_EN
      ena_i = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         tick();
      end
      check("sat.pre", {16'd0, drop_cnt_o}, 32'h0000FFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      ena_i = 1'b0;
      check("sat.cnt", {16'd0, drop_cnt_o}, 32'h0000FFFF);
`else
      ena_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      ena_i = 1'b0;
      check("nocnt.cnt", {16'd0, drop_cnt_o}, 32'd0);
`endif
      check("sat.ovf", {31'd0, ovf_o}, 32'd1);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;

      // drain B1, B2 (drops never entered the buffer)
      usedw_i = 8'd0;
      tick();
      check_wr("dr.drain1", 1'b1, 24'hB1);
      tick();
      check_wr("dr.drain2", 1'b1, 24'hB2);
      tick();
      check_wr("dr.idle", 1'b0, 24'hB2);

      // ---------------- full_i blocks writes ----------------
      full_i = 1'b1;
      ena_i  = 1'b1;
      data_i = 24'hD5;
      tick();
      ena_i = 1'b0;
      check_wr("full.blk", 1'b0, 24'hB2);
      tick();
      tick();
      check_wr("full.blk2", 1'b0, 24'hB2);
      full_i = 1'b0;
      tick();
      check_wr("full.wr", 1'b1, 24'hD5);
      tick();
      check_wr("full.once", 1'b0, 24'hD5);

      // ---------------- async reset with a word buffered ----------------
      full_i = 1'b1;
      ena_i  = 1'b1;
      data_i = 24'hE7;
      tick();
      ena_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check_wr("arst", 1'b0, 24'h0);
      check("arst.ready", {31'd0, ready_o}, 32'd0);
      full_i = 1'b0;
      tick();
      check("arst.hold.ready", {31'd0, ready_o}, 32'd0);
      rst_i = 1'b0;
      tick();
      check("arst.rel.ready", {31'd0, ready_o}, 32'd1);
      check_wr("arst.stale1", 1'b0, 24'h0);
      tick();
      tick();
      check_wr("arst.stale2", 1'b0, 24'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_writer.md
FIFO_WRITER -- requirements
Module: fifo_writer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 24, sample data width.
REQ-002 SHALL have parameter USEDW_WIDTH, default 8, width of FIFO fill-level input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 256, word capacity of downstream FIFO.
REQ-004 SHALL have parameter AFULL_MARGIN, default 2, write-stop margin below FIFO_DEPTH.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port data_i  input  D_WIDTH  upstream sample.
REQ-008 SHALL have port ena_i  input  1  upstream sample strobe, one word per high cycle.
REQ-009 SHALL have port ready_o  output  1  writer can accept a sample this cycle.
REQ-010 SHALL have port full_i  input  1  FIFO full flag.
REQ-011 SHALL have port usedw_i  input  USEDW_WIDTH  FIFO fill level.
REQ-012 SHALL have port wrreq_o  output  1  FIFO write request, one word per high cycle.
REQ-013 SHALL have port data_o  output  D_WIDTH  FIFO write data.
REQ-014 SHALL have port clr_i  input  1  synchronous clear of overflow status.
REQ-015 SHALL have port ovf_o  output  1  sticky overflow flag.
REQ-016 SHALL have port drop_cnt_o  output  16  dropped-sample count.

Function
REQ-017 SHALL contain a 2-entry in-order skid buffer with states EMPTY, ONE, TWO (entries held).
REQ-018 SHALL define push = ena_i & ready_o; drop = ena_i & ~ready_o.
REQ-019 SHALL define can_wr = ~full_i & (usedw_i < FIFO_DEPTH - AFULL_MARGIN).
REQ-020 SHALL, on each edge where (state != EMPTY or push) and can_wr, register wrreq_o=1 and data_o = oldest buffered word, or data_i when state is EMPTY (latency 1 cycle from ena_i to wrreq_o).
REQ-021 SHALL register wrreq_o=0 on every other edge; data_o holds its last value while wrreq_o is low.
REQ-022 SHALL make transitions: EMPTY->ONE on push & ~can_wr; ONE->TWO on push & ~can_wr; ONE->EMPTY on ~push & can_wr; TWO->ONE on can_wr; all other cases hold state.
REQ-023 SHALL register ready_o = (next state != TWO).
REQ-024 SHALL preserve word order; no word written twice; no accepted word lost.
REQ-025 SHALL never assert wrreq_o on an edge where full_i was sampled high.
REQ-026 SHALL, on drop, set ovf_o and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-027 SHALL, on clr_i, clear ovf_o and drop_cnt_o; simultaneous clr_i and drop yields ovf_o=1, drop_cnt_o=1.

Reset
REQ-028 SHALL, while rst_i is high, force wrreq_o=0, data_o=0, ready_o=0, ovf_o=0, drop_cnt_o=0, state EMPTY, buffer contents 0.
REQ-029 SHALL assert ready_o on the first clock edge after rst_i deasserts; reset mid-operation discards buffered words.

Configuration
REQ-030 SHALL implement drop_cnt_o counter only when macro FIFO_WRITER_DROP_CNT_EN is defined.
REQ-031 SHALL, without FIFO_WRITER_DROP_CNT_EN, tie drop_cnt_o to 0; ovf_o behaviour is unchanged.

Verification
REQ-032 SHALL cover: usedw_i=0, ena_i high 4 cycles with data 1,2,3,4 -> wrreq_o high 4 cycles, one cycle later, data_o 1,2,3,4.
REQ-033 SHALL cover: usedw_i=254 (FIFO_DEPTH-AFULL_MARGIN), ena_i with 0xA1,0xA2 -> no wrreq_o, state TWO, ready_o low; usedw_i drops to 10 -> 0xA1,0xA2 written in order on consecutive cycles.
REQ-034 SHALL cover: state TWO, ena_i high 3 cycles -> 3 drops, ovf_o=1, drop_cnt_o=3; clr_i pulse -> both 0.
REQ-035 SHALL cover: drop_cnt_o preloaded to 0xFFFE via drops, 3 more drops -> drop_cnt_o=0xFFFF; macro undefined -> drop_cnt_o stays 0.
REQ-036 SHALL cover: full_i=1 with usedw_i=0 and 1 sample pushed -> no wrreq_o until full_i=0, then word written once.
REQ-037 SHALL cover: rst_i asserted asynchronously with state ONE -> outputs 0 immediately; after release, ready_o=1 one edge later and stale word never written.
